alu_exception_unit: RTL
=======================

Name: alu_exception_unit

Overview:
- Execute-stage consumer of the ALU's result and 8-bit status vector.
- Registers the result, maintains condition flags and sticky trap flags, and detects arithmetic traps.
- Raises a held exception request with EPC and cause to the control unit, and stalls the pipeline until the request is acknowledged.
- Sits between the ALU and the EX/MEM register and exception control.

Parameters:
- PC_W, 32, width of the PC and EPC.
- CNT_W, 8, width of the saturating trap counter.
- CAUSE_OV, 4'hC, cause code for arithmetic overflow.
- CAUSE_DZ, 4'h9, cause code for divide-by-zero.
- CAUSE_AD, 4'h4, cause code for misaligned address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  the ALU outputs this cycle belong to a live instruction.
- ex_pc  in  PC_W  PC of the instruction in EX.
- ex_chk_align  in  1  the instruction is a load/store; honour status bit 3.
- alu_result  in  32  ALU result; may be X on trap.
- alu_status  in  8  status bits: [7] zero, [6] overflow, [5] carry, [4] negative, [3] misaligned, [2] divide-by-zero; [1:0] unused.
- exc_ack  in  1  control unit has taken the exception.
- status_clr  in  1  software clear of the sticky flags and the trap counter.
- res_q  out  32  registered ALU result.
- res_valid  out  1  res_q is valid this cycle.
- cond_q  out  3  {zero, carry, negative} of the last non-trapping instruction.
- sticky_q  out  3  {ov, dz, ad} accumulated since the last clear.
- exc_req  out  1  exception pending.
- exc_cause  out  4  cause code of the pending exception.
- epc  out  PC_W  PC of the trapping instruction.
- ex_stall  out  1  freeze EX and earlier stages.
- trap_cnt  out  CNT_W  saturating count of traps.

Behaviour:
- Reset (asynchronous): every output is 0; the FSM goes to IDLE. Asserting rst while in PENDING drops exc_req and ex_stall immediately.
- Trap decode (combinational):
  - dz = alu_status[2]
  - ov = alu_status[6]
  - ad = alu_status[3] & ex_chk_align
  - trap = ex_valid & (dz | ov | ad)
  - Priority: dz > ov > ad. Only the highest-priority trap sets the cause; all asserted trap bits still set sticky_q.
- FSM IDLE, trap: next cycle exc_req=1, exc_cause=code, epc=ex_pc, res_valid=0. res_q and cond_q hold their values; the X result is never captured. State goes to PENDING.
- FSM IDLE, ex_valid & !trap: next cycle res_q=alu_result, res_valid=1, cond_q={status[7],status[5],status[4]}.
- FSM IDLE, !ex_valid: res_valid=0; all other registers hold.
- FSM PENDING:
  - exc_req=1 and ex_stall=1 (combinational from state); ex_valid is ignored.
  - exc_cause and epc are frozen.
  - res_valid=0.
- FSM PENDING, exc_ack: return to IDLE next cycle; exc_req deasserts that edge. The instruction present on the ack cycle is ignored (it was stalled) and is re-presented the following cycle.
- exc_ack in IDLE: ignored.
- Latency: one cycle from ALU outputs to res_q / exc_req.
- sticky_q: bits OR in on each trap.
  - status_clr alone clears sticky_q and trap_cnt.
  - status_clr together with a trap: the new trap bits win; sticky_q = new bits, trap_cnt = 1.
- trap_cnt: +1 per accepted trap; saturates at 2^CNT_W-1.
- The unit does not feed status back to the ALU.

Decomposition:
- Shared package mips_pkg:
  - status bit indices (ST_ZERO=7, ST_OV=6, ST_CARRY=5, ST_NEG=4, ST_AD=3, ST_DZ=2)
  - cause code constants
  - FSM state encoding (IDLE=1'b0, PENDING=1'b1)
- One sub-module, trap_prio_enc: combinational priority encoder {dz,ov,ad} -> {trap, cause}.
- Everything else stays in the top module.

Test Plan:
- Add 5+7, status 8'h00, ex_valid=1 -> next cycle res_q=12, res_valid=1, cond_q=3'b000, exc_req=0.
- Status 8'h40 (overflow) at ex_pc=32'h0040_0010 -> next cycle exc_req=1, exc_cause=4'hC, epc=32'h0040_0010, ex_stall=1, sticky_q=3'b100, trap_cnt=1. Hold for 3 cycles; exc_ack -> exc_req=0 next cycle.
- Status 8'h44 (ov+dz) -> exc_cause=4'h9, sticky_q=3'b110.
- Status 8'h08 with ex_chk_align=0 -> no trap, res_valid=1. With ex_chk_align=1 -> cause 4'h4.
- Assert rst while PENDING -> exc_req, ex_stall, epc and sticky_q all 0 immediately. status_clr on the same cycle as a dz trap -> sticky_q=3'b010, trap_cnt=1.
- Issue 260 dz traps, each acked -> trap_cnt saturates at 255. Result 0 with status 8'h80 -> cond_q=3'b100.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the execute-stage exception logic.
//   ST_*  : bit positions inside the ALU's 8-bit status vector
//   EXC_* : default exception cause codes
//   state_t : exception FSM encoding
package mips_pkg;
    localparam int ST_ZERO  = 7;
    localparam int ST_OV    = 6;
    localparam int ST_CARRY = 5;
    localparam int ST_NEG   = 4;
    localparam int ST_AD    = 3;
    localparam int ST_DZ    = 2;
    localparam logic [3:0] EXC_OV = 4'hC;
    localparam logic [3:0] EXC_DZ = 4'h9;
    localparam logic [3:0] EXC_AD = 4'h4;
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;
endpackage

// File: rtl/alu_exception_unit_if.sv
// alu_exception_unit_if: ALU-side inputs and result/exception outputs of the EX exception unit.
//   master : ALU / pipeline control side (drives ALU outputs, ack, clear)
//   slave  : alu_exception_unit (drives registered result, flags, exception request)
interface alu_exception_unit_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 8
);
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_chk_align;
    logic [31:0]      alu_result;
    logic [7:0]       alu_status;
    logic             exc_ack;
    logic             status_clr;
    logic [31:0]      res_q;
    logic             res_valid;
    logic [2:0]       cond_q;
    logic [2:0]       sticky_q;
    logic             exc_req;
    logic [3:0]       exc_cause;
    logic [PC_W-1:0]  epc;
    logic             ex_stall;
    logic [CNT_W-1:0] trap_cnt;
    modport master (
        output ex_valid, ex_pc, ex_chk_align, alu_result, alu_status, exc_ack, status_clr,
        input  res_q, res_valid, cond_q, sticky_q, exc_req, exc_cause, epc, ex_stall, trap_cnt
    );
    modport slave (
        input  ex_valid, ex_pc, ex_chk_align, alu_result, alu_status, exc_ack, status_clr,
        output res_q, res_valid, cond_q, sticky_q, exc_req, exc_cause, epc, ex_stall, trap_cnt
    );
endinterface

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: priority encoder of trap conditions, divide-by-zero > overflow > misaligned.
//   dz, ov, ad : trap conditions
//   trap       : any condition present
//   cause      : cause code of the highest-priority condition (0 when none)
module trap_prio_enc import mips_pkg::*; #(
    parameter logic [3:0] CAUSE_OV = EXC_OV,
    parameter logic [3:0] CAUSE_DZ = EXC_DZ,
    parameter logic [3:0] CAUSE_AD = EXC_AD
) (
    input  logic       dz,
    input  logic       ov,
    input  logic       ad,
    output logic       trap,
    output logic [3:0] cause
);
    assign trap  = dz | ov | ad;
    assign cause = dz ? CAUSE_DZ : ov ? CAUSE_OV : ad ? CAUSE_AD : 4'h0;
endmodule

// File: rtl/alu_exception_unit.sv
// alu_exception_unit: registers ALU results and flags, detects arithmetic traps and
// holds an exception request (with EPC and cause) that stalls EX until acknowledged.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_exception_unit_if.slave (ALU outputs in; result, flags, exception out)
module alu_exception_unit import mips_pkg::*; #(
    parameter int         PC_W     = 32,
    parameter int         CNT_W    = 8,
    parameter logic [3:0] CAUSE_OV = EXC_OV,
    parameter logic [3:0] CAUSE_DZ = EXC_DZ,
    parameter logic [3:0] CAUSE_AD = EXC_AD
) (
    input logic                 clk,
    input logic                 rst,
    alu_exception_unit_if.slave bus
);
    state_t           state, state_n;
    logic             dz, ov, ad, trap_any, trap, accept;
    logic [3:0]       cause;
    logic [2:0]       sticky_n;
    logic [CNT_W-1:0] cnt_n;
    logic             unused_status;

    assign dz = bus.alu_status[ST_DZ];
    assign ov = bus.alu_status[ST_OV];
    assign ad = bus.alu_status[ST_AD] & bus.ex_chk_align;
    assign unused_status = ^bus.alu_status[1:0];

    trap_prio_enc #(.CAUSE_OV(CAUSE_OV), .CAUSE_DZ(CAUSE_DZ), .CAUSE_AD(CAUSE_AD)) u_enc (
        .dz    (dz),
        .ov    (ov),
        .ad    (ad),
        .trap  (trap_any),
        .cause (cause)
    );

    // Instructions are only taken in IDLE; while PENDING the stalled one is re-presented later.
    always_comb begin
        trap     = (state == IDLE) && bus.ex_valid && trap_any;
        accept   = (state == IDLE) && bus.ex_valid && !trap_any;
        state_n  = (state == IDLE) ? (trap ? PENDING : IDLE) : (bus.exc_ack ? IDLE : PENDING);
        sticky_n = (bus.status_clr ? 3'b000 : bus.sticky_q) | (trap ? {ov, dz, ad} : 3'b000);
        cnt_n    = bus.status_clr ? CNT_W'(trap)
                 : (trap && bus.trap_cnt != '1) ? bus.trap_cnt + CNT_W'(1) : bus.trap_cnt;
    end

    assign bus.exc_req  = (state == PENDING);
    assign bus.ex_stall = (state == PENDING);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.res_q     <= '0;
            bus.res_valid <= 1'b0;
            bus.cond_q    <= '0;
            bus.sticky_q  <= '0;
            bus.exc_cause <= '0;
            bus.epc       <= '0;
            bus.trap_cnt  <= '0;
        end else begin
            bus.res_valid <= accept;
            if (accept) begin
                bus.res_q  <= bus.alu_result;
                bus.cond_q <= {bus.alu_status[ST_ZERO], bus.alu_status[ST_CARRY], bus.alu_status[ST_NEG]};
            end
            if (trap) begin
                bus.exc_cause <= cause;
                bus.epc       <= bus.ex_pc;
            end
            bus.sticky_q <= sticky_n;
            bus.trap_cnt <= cnt_n;
        end
endmodule
